// File: rtl/clk_en_sequencer.sv
// clk_en_sequencer: programmable clock-enable strobe generator (burst or continuous)
// Ports: clk_in/rst (async active-high); cfg_valid/cfg_ready/cfg_div/cfg_count config
//   handshake (accepted only in IDLE); start/stop run control; en_out one-cycle strobe
//   every max(cfg_div,1) cycles; busy while running; done after a counted run;
//   pulse_cnt strobes in current/last run.
// Optional: define SQUARE_OUT_EN to add sq_out, toggling on every strobe.
module clk_en_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEF_DIV = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             en_out,
  output logic             busy,
  output logic             done,
`ifdef SQUARE_OUT_EN
  output logic             sq_out,
`endif
  output logic [CNT_W-1:0] pulse_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_next;
  logic [WIDTH-1:0] period, cnt, pm1;
  logic [CNT_W-1:0] count;
  logic last, tick;
  assign cfg_ready = (state == IDLE);
  assign pm1 = (period == '0) ? '0 : period - 1'b1;
  // The count-th strobe is still visible on en_out; the run ends on the following edge.
  assign last = en_out && (count != '0) && (pulse_cnt == count);
  assign tick = (state == RUN) && !stop && !last && (cnt == pm1);
  always_comb begin
    state_next = state;
    if (state == IDLE)
      state_next = start ? RUN : IDLE;
    else if (state == RUN)
      state_next = stop ? IDLE : (last ? FINISH : RUN);
    else
      state_next = IDLE;
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      period    <= WIDTH'(DEF_DIV);
      count     <= '0;
      cnt       <= '0;
      en_out    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
`ifdef SQUARE_OUT_EN
      sq_out    <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      en_out <= tick;
      busy   <= (state_next == RUN);
      done   <= (state_next == FINISH);
      if (cfg_valid && cfg_ready) begin
        period <= cfg_div;
        count  <= cfg_count;
      end
      if (state == IDLE && start) begin
        cnt       <= '0;
        pulse_cnt <= '0;
`ifdef SQUARE_OUT_EN
        sq_out    <= 1'b0;
`endif
      end else if (state == RUN) begin
        cnt       <= (cnt == pm1) ? '0 : cnt + 1'b1;
        pulse_cnt <= pulse_cnt + CNT_W'(tick);
`ifdef SQUARE_OUT_EN
        sq_out    <= sq_out ^ tick;
`endif
      end
    end
  end
endmodule
